// File: rtl/lz77_pkg.sv
// Shared LZ77 constants, decoder state encoding and the clogb2 helper,
// common to the encoder and decoder.
package lz77_pkg;

  localparam int MAX_MATCH_LEN = 258;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COPY    = 2'd1,
    ST_LITERAL = 2'd2
  } lz77_state_e;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lz77_history_ram.sv
// Simple dual-port history buffer: one write port, one registered read port
// with read enable so the read data holds while the consumer is stalled.
module lz77_history_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands (match_position, match_length, next_symbol)
// tokens into a byte stream backed by a circular history RAM.
//   state      | meaning
//   ST_IDLE    | waiting for a token, token_ready high
//   ST_COPY    | replaying match bytes; first cycle only primes the RAM read
//   ST_LITERAL | presenting next_symbol
module lz77_decoder
  import lz77_pkg::*;
#(
  parameter int DATA_WIDTH           = 8,
  parameter int DICTIONARY_DEPTH     = 2048,
  parameter int DICTIONARY_DEPTH_LOG = clogb2(DICTIONARY_DEPTH),
  parameter int CNT_WIDTH            = clogb2(MAX_MATCH_LEN)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            token_valid,
  output logic                            token_ready,
  input  logic [DICTIONARY_DEPTH_LOG-1:0] match_position,
  input  logic [CNT_WIDTH-1:0]            match_length,
  input  logic [DATA_WIDTH-1:0]           next_symbol,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     byte_count,
  output logic                            dist_error,
  output logic                            len_error
);

  localparam int                   AW       = DICTIONARY_DEPTH_LOG;
  localparam logic [AW:0]          FILL_MAX = (AW+1)'(DICTIONARY_DEPTH);
  localparam logic [AW:0]          FILL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
  localparam logic [CNT_WIDTH-1:0] LEN_MAX  = CNT_WIDTH'(MAX_MATCH_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  lz77_state_e           state, state_nxt;
  logic                  primed;
  logic [AW-1:0]         pos_q, wr_ptr, rd_addr;
  logic [AW:0]           fill;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] sym_q, last_byte, ram_q;
  logic                  derr_q, accept, out_hs, rd_en;
  logic                  len_bad, zero_len, dist_bad;

  assign token_ready = rst_n && (state == ST_IDLE);
  assign accept      = token_valid && token_ready;
  assign len_bad     = match_length > LEN_MAX;
  assign zero_len    = len_bad || (match_length == '0);
  // Distance (position+1) exceeds min(fill, depth) exactly when position >= fill.
  assign dist_bad    = {1'b0, match_position} >= fill;

  assign out_valid = (state == ST_LITERAL) || ((state == ST_COPY) && primed);
  assign out_hs    = out_valid && out_ready;

  // Once primed, the address already points at the byte after the one shown,
  // so a handshake can launch the next read without a bubble.
  assign rd_en   = (state == ST_COPY) && (!primed || out_hs);
  assign rd_addr = primed ? (wr_ptr - pos_q) : (wr_ptr - pos_q - PTR_ONE);

  always_comb begin
    out_data = '0;
    if (state == ST_LITERAL) begin
      out_data = sym_q;
    end else if ((state == ST_COPY) && primed && !derr_q) begin
      // Distance 1 reads the byte being written this cycle, so bypass the RAM.
      out_data = (pos_q == '0) ? last_byte : ram_q;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (accept) state_nxt = zero_len ? ST_LITERAL : ST_COPY;
      ST_COPY:    if (out_hs && (cnt_q == CNT_ONE)) state_nxt = ST_LITERAL;
      ST_LITERAL: if (out_hs) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed     <= 1'b0;
      pos_q      <= '0;
      cnt_q      <= '0;
      sym_q      <= '0;
      derr_q     <= 1'b0;
      wr_ptr     <= '0;
      fill       <= '0;
      last_byte  <= '0;
      byte_count <= '0;
      dist_error <= 1'b0;
      len_error  <= 1'b0;
    end else begin
      if (accept) begin
        primed <= 1'b0;
        pos_q  <= match_position;
        cnt_q  <= len_bad ? '0 : match_length;
        sym_q  <= next_symbol;
        derr_q <= dist_bad;
        if (len_bad)                     len_error  <= 1'b1;
        else if (!zero_len && dist_bad)  dist_error <= 1'b1;
      end else if (state == ST_COPY) begin
        if (!primed)     primed <= 1'b1;
        else if (out_hs) cnt_q  <= cnt_q - CNT_ONE;
      end
      if (out_hs) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        last_byte  <= out_data;
        byte_count <= byte_count + 32'd1;
        if (fill != FILL_MAX) fill <= fill + FILL_ONE;
      end
    end
  end

  lz77_history_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DICTIONARY_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_history (
    .clk     (clk),
    .wr_en   (out_hs),
    .wr_addr (wr_ptr),
    .wr_data (out_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed-vector bench for lz77_decoder: hand-computed byte streams, latency,
// back-pressure, error flags and reset behaviour.
module tb_lz77_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        token_valid;
  logic        token_ready;
  logic [10:0] match_position;
  logic [8:0]  match_length;
  logic [7:0]  next_symbol;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] byte_count;
  logic        dist_error;
  logic        len_error;

  int   n_vec = 0;
  int   n_err = 0;
  int   ncyc = 0;
  bit   rand_mode = 1'b0;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];
  int         acc_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  lz77_decoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .token_valid    (token_valid),
    .token_ready    (token_ready),
    .match_position (match_position),
    .match_length   (match_length),
    .next_symbol    (next_symbol),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .byte_count     (byte_count),
    .dist_error     (dist_error),
    .len_error      (len_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte collector plus hold check while stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_cyc.push_back(ncyc);
    end
    if (rst_n && stall_prev) begin
      check_val("stall_valid", 32'(out_valid), 32'd1);
      check_val("stall_data", 32'(out_data), 32'(stall_data));
    end
    stall_prev <= rst_n && out_valid && !out_ready;
    stall_data <= out_data;
  end

  function automatic logic [7:0] lit(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic clear_streams();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic do_reset();
    token_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_token_ready", 32'(token_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_byte_count", byte_count, 32'd0);
    check_val("rst_dist_error", 32'(dist_error), 32'd0);
    check_val("rst_len_error", 32'(len_error), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_streams();
    @(negedge clk);
    check_val("rst_release_ready", 32'(token_ready), 32'd1);
  endtask

  task automatic send_token(input int pos, input int len, input logic [7:0] sym);
    int budget = 0;
    @(posedge clk); #1;
    match_position = 11'(pos);
    match_length   = 9'(len);
    next_symbol    = sym;
    token_valid    = 1'b1;
    @(negedge clk);
    while (!token_ready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check_val("token_accept", 32'(token_ready), 32'd1);
    acc_q.push_back(ncyc);
    @(posedge clk); #1;
    token_valid = 1'b0;
  endtask

  task automatic run_check(input string tag);
    int budget = 0;
    while (got_q.size() < exp_q.size() && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    check_val({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_val($sformatf("%s_b%0d", tag, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead_beef, 32'(exp_q[i]));
  endtask

  task automatic send_shells();
    send_token(0, 0, " ");
    send_token(0, 0, "s");
    send_token(0, 0, "h");
    send_token(0, 0, "e");
    send_token(3, 2, "e");
    send_token(0, 0, "l");
    send_token(0, 1, "s");
    send_token(5, 3, "a");
    send_token(13, 4, "l");
    send_token(10, 2, ".");
  endtask

  initial begin
    token_valid = 1'b0;
    match_position = '0;
    match_length = '0;
    next_symbol = '0;

    // Basic overlapping-copy example
    do_reset();
    push_str("aacaacabcabaaac");
    send_token(0, 0, "a");
    send_token(0, 1, "c");
    send_token(2, 4, "b");
    send_token(2, 3, "a");
    send_token(11, 2, "c");
    run_check("ex1");
    check_val("ex1_count", byte_count, 32'd15);
    check_val("ex1_dist_err", 32'(dist_error), 32'd0);

    // Run-length copy: latency and back-to-back bytes
    do_reset();
    push_str("aaaaaab");
    send_token(0, 0, "a");
    send_token(0, 5, "b");
    run_check("run6");
    if (got_cyc.size() >= 2 && acc_q.size() >= 2) begin
      check_val("lit_latency", 32'(got_cyc[0] - acc_q[0]), 32'd1);
      check_val("copy_latency", 32'(got_cyc[1] - acc_q[1]), 32'd2);
    end
    for (int i = 2; i < 7 && i < got_cyc.size(); i++)
      check_val($sformatf("run6_gap%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);

    // Shells string, full throughput then random back-pressure
    do_reset();
    push_str(" she sells sea shells.");
    send_shells();
    run_check("shells");
    check_val("shells_count", byte_count, 32'd22);

    do_reset();
    rand_mode = 1'b1;
    push_str(" she sells sea shells.");
    send_shells();
    run_check("shells_bp");
    rand_mode = 1'b0;
    clear_streams();

    // Maximum legal length, then an over-long token
    for (int i = 0; i < 258; i++) exp_q.push_back(".");
    exp_q.push_back("w");
    send_token(0, 258, "w");
    run_check("len258");
    check_val("len258_err", 32'(len_error), 32'd0);
    clear_streams();
    push_str("q");
    send_token(0, 259, "q");
    run_check("len259");
    check_val("len259_err", 32'(len_error), 32'd1);
    check_val("len259_dist", 32'(dist_error), 32'd0);
    check_val("len259_count", byte_count, 32'd282);

    // Distance boundary against fill level
    do_reset();
    push_str("abac");
    send_token(0, 0, "a");
    send_token(0, 0, "b");
    send_token(1, 1, "c");
    run_check("dist_ok");
    check_val("dist_ok_err", 32'(dist_error), 32'd0);
    clear_streams();
    exp_q.push_back(8'h00);
    push_str("d");
    send_token(4, 1, "d");
    run_check("dist_over");
    check_val("dist_over_err", 32'(dist_error), 32'd1);

    // Out-of-range first token
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
    push_str("x");
    send_token(4, 3, "x");
    run_check("first_bad");
    check_val("first_bad_err", 32'(dist_error), 32'd1);
    check_val("first_bad_count", byte_count, 32'd4);

    // Reset in the middle of a long copy
    do_reset();
    send_token(0, 0, "p");
    send_token(0, 0, "q");
    send_token(1, 200, "r");
    repeat (6) @(negedge clk);
    check_val("midcopy_active", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_data", 32'(out_data), 32'd0);
    check_val("mid_rst_ready", 32'(token_ready), 32'd0);
    check_val("mid_rst_count", byte_count, 32'd0);
    check_val("mid_rst_derr", 32'(dist_error), 32'd0);
    check_val("mid_rst_lerr", 32'(len_error), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_streams();
    @(negedge clk);
    check_val("mid_rel_ready", 32'(token_ready), 32'd1);
    check_val("mid_rel_valid", 32'(out_valid), 32'd0);
    push_str("kkm");
    send_token(0, 0, "k");
    send_token(0, 1, "m");
    run_check("after_rst");
    check_val("after_rst_count", byte_count, 32'd3);
    check_val("after_rst_derr", 32'(dist_error), 32'd0);

    // Wrap the history: full-depth distance after 2100 literals
    do_reset();
    for (int i = 0; i < 2100; i++) send_token(0, 0, lit(i));
    repeat (4) @(negedge clk);
    check_val("wrap_count", byte_count, 32'd2100);
    clear_streams();
    for (int i = 52; i < 56; i++) exp_q.push_back(lit(i));
    push_str("z");
    send_token(2047, 4, "z");
    run_check("wrap");
    check_val("wrap_dist_err", 32'(dist_error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
